pts_tx_ctrl: RTL and testbench

PTS_TX_CTRL -- requirements
Module: pts_tx_ctrl

---
 rtl/pts_tx_ctrl_if.sv | 33 +++
 rtl/pts_tx_ctrl.sv | 96 +++++++++
 tb/tb_pts_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pts_tx_ctrl_if.sv
// rtl/pts_tx_ctrl_if.sv - upstream word handshake and shift-register strobe bundle for pts_tx_ctrl.
// frame_count exists only when PTS_TX_FRAME_CNT_EN is defined.
interface pts_tx_ctrl_if #(
  parameter int NUM_BITS = 8
);
  logic                in_valid;
  logic [NUM_BITS-1:0] in_data;
  logic                in_ready;
  logic                sr_load_enable;
  logic                sr_shift_enable;
  logic [NUM_BITS-1:0] sr_parallel_in;
  logic                busy;
  logic                frame_done;
`ifdef PTS_TX_FRAME_CNT_EN
  logic [15:0]         frame_count;
`endif

  modport master (
    output in_valid, in_data,
    input  in_ready, sr_load_enable, sr_shift_enable, sr_parallel_in, busy, frame_done
`ifdef PTS_TX_FRAME_CNT_EN
    , input frame_count
`endif
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, sr_load_enable, sr_shift_enable, sr_parallel_in, busy, frame_done
`ifdef PTS_TX_FRAME_CNT_EN
    , output frame_count
`endif
  );
endinterface

// File: rtl/pts_tx_ctrl.sv
// rtl/pts_tx_ctrl.sv - parallel-to-serial transmit controller (IDLE/LOAD/SEND/DONE), MSB first.
// Optional frame counter output enabled by defining PTS_TX_FRAME_CNT_EN.
module pts_tx_ctrl #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  pts_tx_ctrl_if.slave  bus
);
  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(NUM_BITS);
  localparam logic [CLK_W-1:0] CLK_TC   = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [CLK_W-1:0]    r_clk_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [NUM_BITS-1:0] r_word;

  logic w_idle;
  logic w_clk_tc;
  logic w_bit_last;

  assign w_idle     = (r_state == S_IDLE);
  assign w_clk_tc   = (r_clk_cnt == CLK_TC);
  assign w_bit_last = (r_bit_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_word    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_word  <= bus.in_data;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_state   <= S_SEND;
        end
        S_SEND: begin
          if (w_clk_tc) begin
            r_clk_cnt <= '0;
            // The last bit period ends the frame instead of shifting again.
            if (w_bit_last) begin
              r_state <= S_DONE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready        = w_idle & ~rst;
  assign bus.sr_load_enable  = (r_state == S_LOAD);
  assign bus.sr_shift_enable = (r_state == S_SEND) & w_clk_tc & ~w_bit_last;
  assign bus.sr_parallel_in  = r_word;
  assign bus.busy            = ~w_idle;
  assign bus.frame_done      = (r_state == S_DONE);

`ifdef PTS_TX_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_count <= '0;
    end else if (r_state == S_DONE) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign bus.frame_count = r_frame_count;
`endif
endmodule

// File: tb/tb_pts_tx_ctrl.sv
// tb/tb_pts_tx_ctrl.sv - scoreboard bench for pts_tx_ctrl with CLKS_PER_BIT=4 and CLKS_PER_BIT=1 instances.
// Stimulus pushes expected strobe events; a negedge monitor pops and compares them.
module tb_pts_tx_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pts_tx_ctrl_if #(.NUM_BITS(8)) if0 ();
  pts_tx_ctrl_if #(.NUM_BITS(8)) if1 ();

  pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(4)) u0 (.clk(clk), .rst(rst), .bus(if0));
  pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] word;
    logic       ser;
  } evt_t;

  evt_t q0[$];
  evt_t q1[$];
  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  logic [7:0] ser0 = 8'h00;
  logic [7:0] ser1 = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural shift register fed by the DUT strobes; MSB is the serial line.
  always @(posedge clk) begin
    if (if0.sr_load_enable) ser0 <= if0.sr_parallel_in;
    else if (if0.sr_shift_enable) ser0 <= {ser0[6:0], 1'b0};
    if (if1.sr_load_enable) ser1 <= if1.sr_parallel_in;
    else if (if1.sr_shift_enable) ser1 <= {ser1[6:0], 1'b0};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int qsize(input int u);
    return (u == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront_cyc(input int u);
    return (u == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  task automatic qpush(input int u, input evt_t e);
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int u, output evt_t e);
    if (u == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  function automatic logic rdy(input int u);
    return (u == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  task automatic set_in(input int u, input logic v, input logic [7:0] d);
    if (u == 0) begin
      if0.in_valid = v;
      if0.in_data  = d;
    end else begin
      if1.in_valid = v;
      if1.in_data  = d;
    end
  endtask

  // Expected events for a frame whose accepting edge ends cycle base.
  task automatic push_frame(input int u, input int base, input logic [7:0] w, input int cpb);
    evt_t e;
    e.word = w;
    e.kind = 0; e.cyc = base + 1; e.ser = 1'b0;
    qpush(u, e);
    for (int k = 0; k < 7; k++) begin
      e.kind = 1; e.cyc = base + 1 + (k + 1) * cpb; e.ser = w[7 - k];
      qpush(u, e);
    end
    e.kind = 2; e.cyc = base + 2 + 8 * cpb; e.ser = w[0];
    qpush(u, e);
  endtask

  task automatic observe(input int u, input logic ld, input logic sh, input logic dn,
                         input logic [7:0] pin, input logic ser);
    evt_t e;
    logic act [3];
    act[0] = ld; act[1] = sh; act[2] = dn;
    if (ld && sh) fail("load_shift_overlap", 1, 0);
    while (qsize(u) > 0 && qfront_cyc(u) < cyc) begin
      qpop(u, e);
      fail($sformatf("missed_event_u%0d_kind%0d", u, e.kind), cyc, e.cyc);
    end
    for (int k = 0; k < 3; k++) begin
      if (act[k]) begin
        if (qsize(u) == 0) begin
          fail($sformatf("unexpected_event_u%0d_kind%0d", u, k), cyc, -1);
        end else begin
          qpop(u, e);
          chk($sformatf("event_kind_u%0d", u), k, e.kind);
          chk($sformatf("event_cycle_u%0d_kind%0d", u, k), cyc, e.cyc);
          chk($sformatf("parallel_in_u%0d", u), pin, e.word);
          if (k != 0) chk($sformatf("serial_bit_u%0d", u), ser, e.ser);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, if0.sr_load_enable, if0.sr_shift_enable, if0.frame_done, if0.sr_parallel_in, ser0[7]);
    observe(1, if1.sr_load_enable, if1.sr_shift_enable, if1.frame_done, if1.sr_parallel_in, ser1[7]);
    if (if0.frame_done) done_cnt++;
  end

  task automatic wait_ready(input int u, input int exp_cyc);
    int n = 0;
    while (!rdy(u) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail($sformatf("ready_timeout_u%0d", u), n, 200);
    else chk($sformatf("ready_cycle_u%0d", u), cyc, exp_cyc);
  endtask

  task automatic start_frame(input int u, input logic [7:0] w, input int cpb, output int base);
    wait_ready(u, cyc);
    set_in(u, 1'b1, w);
    base = cyc;
    push_frame(u, base, w, cpb);
    @(negedge clk);
    set_in(u, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int d0;
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", if0.in_ready, 0);
    chk("rst_load", if0.sr_load_enable, 0);
    chk("rst_shift", if0.sr_shift_enable, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_done", if0.frame_done, 0);
    chk("rst_parallel", if0.sr_parallel_in, 0);
    chk("rst_u1_ready", if1.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", if0.in_ready, 1);

    // Single frame 0xA5.
    @(negedge clk);
    start_frame(0, 8'hA5, 4, b);
    chk("busy_in_load", if0.busy, 1);
    chk("ready_low_in_load", if0.in_ready, 0);
    wait_ready(0, b + 35);

    // Back-to-back 0x3C then 0xFF with in_valid held high.
    set_in(0, 1'b1, 8'h3C);
    b = cyc;
    push_frame(0, b, 8'h3C, 4);
    push_frame(0, b + 35, 8'hFF, 4);
    @(negedge clk);
    set_in(0, 1'b1, 8'hFF);
    while (cyc < b + 35) @(negedge clk);
    chk("b2b_second_accept_ready", if0.in_ready, 1);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    wait_ready(0, b + 70);

    // in_valid pulsed during a frame must be ignored.
    start_frame(0, 8'h5A, 4, b);
    while (cyc < b + 2) @(negedge clk);
    set_in(0, 1'b1, 8'h99);
    while (cyc < b + 21) @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    wait_ready(0, b + 35);
    chk("ignored_parallel_hold", if0.sr_parallel_in, 8'h5A);

    // Reset in cycle 15 of a frame, then 0x81 accepted on the first edge after release.
    start_frame(0, 8'h66, 4, b);
    d0 = done_cnt;
    while (cyc < b + 14) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    #1;
    chk("midrst_in_ready", if0.in_ready, 0);
    chk("midrst_load", if0.sr_load_enable, 0);
    chk("midrst_shift", if0.sr_shift_enable, 0);
    chk("midrst_busy", if0.busy, 0);
    chk("midrst_done", if0.frame_done, 0);
    chk("midrst_parallel", if0.sr_parallel_in, 0);
    set_in(0, 1'b1, 8'h81);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    b = cyc;
    push_frame(0, b, 8'h81, 4);
    #1;
    chk("ready_on_release", if0.in_ready, 1);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    chk("no_done_from_aborted_frame", done_cnt, d0);
    wait_ready(0, b + 35);

    // CLKS_PER_BIT=1 instance, 0x5A.
    start_frame(1, 8'h5A, 1, b);
    wait_ready(1, b + 11);

    repeat (3) @(negedge clk);
    chk("u0_queue_drained", q0.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);
    chk("u0_frame_done_total", done_cnt, 5);
`ifdef PTS_TX_FRAME_CNT_EN
    chk("u0_frame_count", if0.frame_count, 16'd1);
    chk("u1_frame_count", if1.frame_count, 16'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
